// File: rtl/state_input_conditioner.sv
// -----------------------------------------------------------------------------
// state_input_conditioner
//
// Front end for the 4-input state machine. Four raw, bouncy event lines are
// debounced, rising edges are detected and queued as pending events, and the
// events are replayed one at a time as one-hot pulses of HOLD_CYCLES cycles
// followed by GAP_CYCLES cycles of all-zero output.
//
// Build option:
//   STATE_COND_SYNC_EN  - when defined, each raw bit passes through a 2-flop
//                         synchronizer before its debouncer (adds 2 cycles of
//                         latency). Leave undefined only when raw_inputs is
//                         already synchronous to clk.
//
// Reset is synchronous and active-high (reset sampled on the rising edge).
// -----------------------------------------------------------------------------
module state_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,   // 1..255
  parameter int unsigned HOLD_CYCLES     = 10,  // 1..255
  parameter int unsigned GAP_CYCLES      = 2    // 0..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_inputs,
  output logic [3:0] state_inputs,
  output logic       busy,
  output logic       dropped
);

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);
  localparam logic [7:0] GAP_INIT  = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic [3:0] synced;

`ifdef STATE_COND_SYNC_EN
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  // Two-stage shift toward the clk domain.
  always_comb begin
    sync1_d = raw_inputs;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared by reset so no stale level survives it.
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would collapse the chain.
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign synced = sync2_q;
`else
  assign synced = raw_inputs;
`endif

  // ---------------------------------------------------------------------------
  // Debounce and rising-edge detection
  // ---------------------------------------------------------------------------
  logic [3:0] db_q, db_d;
  logic [3:0] db_prev_q, db_prev_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [3:0] rise;

  // Per-channel debouncer: the level flips on the DEBOUNCE_CYCLES-th
  // consecutive differing sample; any agreeing sample restarts the count.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (synced[i] == db_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = synced[i];
        cnt_d[i] = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Only rising edges of the debounced level are events.
  assign rise = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------------
  // Pending events and loss detection
  // ---------------------------------------------------------------------------
  logic [3:0] pending_q, pending_d;
  logic       dropped_q, dropped_d;
  logic [3:0] grant_vec;

  // A grant clears its channel, a rise sets it (set wins on a collision), and
  // a rise onto an already-pending, ungranted channel is reported as lost.
  always_comb begin
    pending_d = (pending_q & ~grant_vec) | rise;
    dropped_d = |(rise & pending_q & ~grant_vec);
  end

  // ---------------------------------------------------------------------------
  // Presentation FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [3:0] code_q, code_d;
  logic       try_grant;

  // Next-state logic. The last GAP cycle behaves like IDLE so a queued event
  // can be granted on the edge that ends the gap; that keeps the zero run
  // between back-to-back pulses at exactly GAP_CYCLES (one IDLE cycle when
  // GAP_CYCLES is 0).
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    code_d     = code_q;
    try_grant  = 1'b0;
    grant_vec  = '0;

    unique case (state_q)
      ST_IDLE: begin
        try_grant = 1'b1;
      end
      ST_HOLD: begin
        if (hold_cnt_q == 8'd1) begin
          code_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_INIT;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          try_grant = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
      end
    endcase

    if (try_grant) begin
      state_d = ST_IDLE;
      code_d  = '0;
      // Scan high-to-low so the lowest pending index is the one that sticks.
      for (int i = 3; i >= 0; i--) begin
        if (pending_q[i]) begin
          grant_vec = 4'b0001 << i;
        end
      end
      if (grant_vec != 4'b0000) begin
        state_d    = ST_HOLD;
        code_d     = grant_vec;
        hold_cnt_d = HOLD_INIT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic [3:0] state_inputs_q, state_inputs_d;
  logic       busy_q, busy_d;

  // Output decode from the next state, so the ports are plain flop outputs.
  always_comb begin
    state_inputs_d = (state_d == ST_HOLD) ? code_d : 4'b0000;
    busy_d         = (state_d != ST_IDLE) || (pending_d != 4'b0000);
  end

  // State register for debouncers, pending queue, FSM and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q           <= '0;
      db_prev_q      <= '0;
      // NOTE: the debounce counters are four small registers, not a RAM, so
      // clearing them in reset costs nothing and avoids X on first use.
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q      <= '0;
      dropped_q      <= 1'b0;
      state_q        <= ST_IDLE;
      hold_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      code_q         <= '0;
      state_inputs_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      db_q           <= db_d;
      db_prev_q      <= db_prev_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q      <= pending_d;
      dropped_q      <= dropped_d;
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      code_q         <= code_d;
      state_inputs_q <= state_inputs_d;
      busy_q         <= busy_d;
    end
  end

  assign state_inputs = state_inputs_q;
  assign busy         = busy_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_state_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_state_input_conditioner
//
// Directed scenarios followed by randomized event traffic. Every cycle the
// DUT outputs are compared with a reference model built from the behavioural
// rules: a sample-delay queue for the synchronizer, run-length debouncing,
// a pending bitmap, and a time-slot scheduler that books each granted pulse
// and the earliest edge at which the next grant may happen.
// -----------------------------------------------------------------------------
module tb_state_input_conditioner;

  localparam int D = 4;
  localparam int H = 10;
  localparam int G = 2;
`ifdef STATE_COND_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] raw_inputs;
  logic [3:0] state_inputs;
  logic       busy;
  logic       dropped;

  state_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .GAP_CYCLES     (G)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_inputs  (raw_inputs),
    .state_inputs(state_inputs),
    .busy        (busy),
    .dropped     (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [3:0] m_pipe [$];
  logic [3:0] m_lvl, m_prev, m_pend;
  int         m_run [4];
  int         m_edge;
  logic [3:0] m_code;
  int         m_code_end, m_busy_end, m_free;
  logic [3:0] exp_si;
  logic       exp_busy, exp_drop;

  // Scenario statistics gathered from the DUT.
  int         drop_cnt;
  int         start_cnt [4];
  int         high_cnt [4];
  logic [3:0] last_si;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] raw, input logic rst);
    logic [3:0] syn;
    logic [3:0] rise;
    int         g;
    if (rst) begin
      m_lvl  = '0;
      m_prev = '0;
      m_pend = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_pipe.delete();
      for (int i = 0; i < S; i++) m_pipe.push_back(4'h0);
      m_code     = '0;
      m_code_end = 0;
      m_busy_end = 0;
      m_free     = 0;
      exp_si     = '0;
      exp_busy   = 1'b0;
      exp_drop   = 1'b0;
    end else begin
      if (S == 0) begin
        syn = raw;
      end else begin
        syn = m_pipe.pop_front();
        m_pipe.push_back(raw);
      end
      rise = m_lvl & ~m_prev;
      // Grant: lowest pending channel, once the previous slot has expired.
      g = -1;
      if (m_edge >= m_free) begin
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i] && g < 0) g = i;
        end
      end
      if (g >= 0) begin
        m_code     = 4'(1 << g);
        m_code_end = m_edge + H;
        m_busy_end = m_edge + H + G;
        m_free     = m_edge + H + ((G > 0) ? G : 1);
      end
      exp_drop = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (rise[i] && m_pend[i] && i != g) exp_drop = 1'b1;
        m_pend[i] = (m_pend[i] && i != g) || rise[i];
      end
      // Run-length debounce.
      m_prev = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (syn[i] == m_lvl[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_lvl[i] = syn[i];
            m_run[i] = 0;
          end
        end
      end
      exp_si   = (m_edge < m_code_end) ? m_code : 4'h0;
      exp_busy = (m_edge < m_busy_end) || (m_pend != 4'h0);
    end
    m_edge++;
  endtask

  task automatic tick(input logic [3:0] raw, input logic rst);
    raw_inputs = raw;
    reset      = rst;
    @(posedge clk);
    model_step(raw, rst);
    #1;
    check("state_inputs", {28'd0, state_inputs}, {28'd0, exp_si});
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check("dropped", {31'd0, dropped}, {31'd0, exp_drop});
    check("onehot0", {31'd0, $onehot0(state_inputs)}, 32'd1);
    if (dropped === 1'b1) drop_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (state_inputs[i] === 1'b1) begin
        high_cnt[i]++;
        if (last_si !== state_inputs) start_cnt[i]++;
      end
    end
    last_si = state_inputs;
  endtask

  task automatic clear_stats();
    drop_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      start_cnt[i] = 0;
      high_cnt[i]  = 0;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick(4'h0, 1'b0);
  endtask

  initial begin
    int first;
    int seg;
    logic [3:0] r;
    raw_inputs = 4'h0;
    reset      = 1'b1;
    m_edge     = 0;
    last_si    = 4'h0;
    model_step(4'h0, 1'b1);
    clear_stats();

    // Reset held with all lines high: outputs stay zero throughout.
    for (int i = 0; i < 10; i++) tick(4'hF, 1'b1);
    check("reset_state_inputs", {28'd0, state_inputs}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Release with all four lines high: latency, order, no drops.
    clear_stats();
    first = -1;
    for (int e = 0; e < 80; e++) begin
      tick(4'hF, 1'b0);
      if (first < 0 && state_inputs !== 4'h0) first = e;
    end
    check("first_grant_latency", first, S + D + 1);
    for (int i = 0; i < 4; i++) begin
      check("simul_pulse_count", start_cnt[i], 1);
      check("simul_pulse_width", high_cnt[i], H);
    end
    check("simul_drops", drop_cnt, 0);
    settle(30);

    // Single clean event on ch1.
    clear_stats();
    for (int e = 0; e < 40; e++) tick(4'h2, 1'b0);
    check("single_pulse_count", start_cnt[1], 1);
    check("single_pulse_width", high_cnt[1], H);
    check("single_busy_after", {31'd0, busy}, 32'd0);
    settle(30);

    // Bounce on ch2, then a stable high.
    clear_stats();
    tick(4'h4, 1'b0);
    tick(4'h0, 1'b0);
    tick(4'h4, 1'b0);
    tick(4'h0, 1'b0);
    first = -1;
    for (int e = 0; e < 40; e++) begin
      tick(4'h4, 1'b0);
      if (first < 0 && state_inputs !== 4'h0) first = e;
    end
    check("bounce_latency", first, S + D + 1);
    check("bounce_pulse_count", start_cnt[2], 1);
    settle(30);

    // Overflow: ch3 rises twice while still pending behind ch0.
    clear_stats();
    tick(4'h1, 1'b0);
    for (int e = 0; e < 4; e++) tick(4'h9, 1'b0);
    for (int e = 0; e < 4; e++) tick(4'h1, 1'b0);
    for (int e = 0; e < 34; e++) tick(4'h9, 1'b0);
    check("overflow_drops", drop_cnt, 1);
    check("overflow_ch0_pulses", start_cnt[0], 1);
    check("overflow_ch3_pulses", start_cnt[3], 1);
    settle(30);

    // Reset in the middle of a ch0 hold while ch1 waits.
    clear_stats();
    first = -1;
    for (int e = 0; e < 30 && first < 0; e++) begin
      tick(4'h3, 1'b0);
      if (state_inputs === 4'h1) first = e;
    end
    check("midhold_grant_seen", {31'd0, first >= 0}, 32'd1);
    for (int e = 0; e < 3; e++) tick(4'h3, 1'b0);
    tick(4'h0, 1'b1);
    check("midhold_reset_outputs", {28'd0, state_inputs}, 32'd0);
    check("midhold_reset_busy", {31'd0, busy}, 32'd0);
    clear_stats();
    settle(40);
    check("midhold_no_ch1_after", start_cnt[1], 0);

    // Randomized traffic with occasional resets.
    seg = 0;
    r   = 4'h0;
    for (int c = 0; c < 1500; c++) begin
      if (seg == 0) begin
        r   = 4'($urandom_range(0, 15));
        seg = $urandom_range(1, 12);
      end
      seg--;
      tick(r, ($urandom_range(0, 99) == 0));
    end
    settle(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/state_input_conditioner.md
Name: state_input_conditioner

Overview:
- Upstream stage of the 4-input state machine: drives its `state_inputs` bus.
- Takes four raw, asynchronous, bouncy event lines; debounces each and detects rising edges.
- Queues the events, then presents them one at a time as clean one-hot pulses of fixed width, separated by a guaranteed idle gap.
- The state machine therefore never sees more than one input bit set in any cycle.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive samples a synced input must differ from its debounced level before the level flips (legal 1..255).
- HOLD_CYCLES, 10: cycles a granted one-hot code is held on `state_inputs` (legal 1..255).
- GAP_CYCLES, 2: cycles of all-zero output after each hold (0 legal = no gap).

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- raw_inputs, input, 4: raw event lines; bit i is channel i.
- state_inputs, output, 4: registered one-hot event code to the state machine, or 0.
- busy, output, 1: registered; 1 while FSM is not IDLE or any event is pending.
- dropped, output, 1: registered one-cycle pulse when an event is lost.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Sync flops, debounced levels, edge history, counters, `pending` are cleared; FSM goes to IDLE; `state_inputs`=0, `busy`=0, `dropped`=0. Reset asserted mid-hold or mid-gap aborts immediately: outputs are 0 after that edge and pending events are discarded.
- Debounce, per channel i:
  - `db[i]` resets to 0; counter `cnt[i]` is 8 bits.
  - If synced input equals `db[i]`: `cnt[i]`<=0.
  - Otherwise, if `cnt[i]`==DEBOUNCE_CYCLES-1: `db[i]`<=input and `cnt[i]`<=0; else `cnt[i]`++.
  - Net effect: `db` flips on the DEBOUNCE_CYCLES-th consecutive differing sample. Any matching sample restarts the count.
- Edge detect: `rise[i]` = `db[i]` & ~`db_q[i]`; `db_q` is `db` delayed one cycle. Falling edges are ignored.
- Pending:
  - `rise[i]` sets `pending[i]`. A grant to channel i clears it.
  - Rise and grant on the same channel in the same cycle: set wins, and the new event stays pending.
  - Rise while `pending[i]` is already 1 and not being granted this cycle: event is lost, `dropped`=1 for exactly one cycle (OR across channels).
- FSM (3 states):
  - IDLE: if `pending` != 0, grant the lowest set index i (priority ch0 > ch3), clear `pending[i]`, load `state_inputs`=1<<i, hold counter=HOLD_CYCLES, go to HOLD. Else `state_inputs`=0.
  - HOLD: `state_inputs` stays constant. After HOLD_CYCLES cycles high, go to GAP with gap counter=GAP_CYCLES, or go directly to IDLE if GAP_CYCLES==0. `state_inputs`=0 on exit.
  - GAP: `state_inputs`=0 for GAP_CYCLES cycles, then IDLE.
- A grant can occur on the IDLE edge right after GAP ends. Consecutive events therefore show exactly GAP_CYCLES zero cycles between pulses; with GAP_CYCLES=0 there is exactly 1 zero cycle, the IDLE cycle.
- Latency: with FSM idle, edge 0 is the first edge sampling a raw high. `state_inputs` goes high after edge S+DEBOUNCE_CYCLES+1, where S=2 with the sync feature and 0 without.
- Invariant: `state_inputs` is always 0 or exactly one-hot.

Optional Feature:
- STATE_COND_SYNC_EN defined: each raw bit passes through a 2-flop synchronizer (reset to 0) before debounce; S=2.
- Not defined: `raw_inputs` feeds the debouncers directly; S=0. Use only when inputs are already synchronous to `clk`.

Test Plan:
- Reset: hold reset 10 cycles with `raw_inputs`=4'hF -> `state_inputs`=0, `busy`=0, `dropped`=0 throughout. After release, with defaults and sync enabled, `state_inputs`=4'h1 first appears after edge 7.
- Single clean event, defaults, sync on: `raw_inputs`=4'h2 held -> `state_inputs`=4'h2 for exactly 10 cycles, then 0. `busy` falls after the 2-cycle gap.
- Bounce: ch2 toggles 1,0,1,0 every cycle, then holds 1 -> no output during toggling. Exactly one 4'h4 pulse, starting 7 edges after the first sample of the stable 1.
- Simultaneous events: `raw_inputs` 0->4'hF in one cycle -> pulses 4'h1, 4'h2, 4'h4, 4'h8 in that order. Each pulse is 10 cycles, with 2 zero cycles between; `dropped` never asserts.
- Overflow: ch0 event granted, then during its hold ch3 rises, falls, and rises again (each level held ≥4 cycles) -> `dropped` pulses once on the second rise. Only one 4'h8 pulse follows.
- Reset mid-hold: assert reset on cycle 5 of a 4'h1 hold while ch1 is pending -> `state_inputs`=0 after that edge. No 4'h2 pulse appears after release unless ch1 produces a new rising edge.
